// File: rtl/uart_rx_if.sv
// Host-side result bus of the UART receiver: received byte, strobe, error flags, busy.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, data_valid, parity_err, frame_err, busy);
  modport slave  (input  data_out, data_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 7/8 data bits LSB first, optional even parity, 1 stop bit.
// Optional build macro UART_RX_MAJORITY_EN: majority vote of ticks 6/7/8, decision at tick 8.
module uart_rx #(
  parameter int unsigned DIV_LOW  = 326,
  parameter int unsigned DIV_HIGH = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  input  logic        baud_rate,
  input  logic        parity_switch,
  input  logic        data_length,
  uart_rx_if.master   rx_bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [IDX_W-1:0] SAMP_IDX = IDX_W'(8);
`else
  localparam logic [IDX_W-1:0] SAMP_IDX = IDX_W'(7);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_d;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] tidx;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_acc, par_mis;
  logic             cfg_baud, cfg_par, cfg_len;
  logic             tick_c, decide_c, bit_val_c;
  logic             load_cfg_c, shift_c, par_sample_c, finish_c;
  logic [CNT_W-1:0] reload_idle_c, reload_run_c;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign reload_idle_c = baud_rate ? CNT_W'(DIV_HIGH - 1) : CNT_W'(DIV_LOW - 1);
  assign reload_run_c  = cfg_baud  ? CNT_W'(DIV_HIGH - 1) : CNT_W'(DIV_LOW - 1);
  assign tick_c        = (state != IDLE) && (cnt == '0);
  assign decide_c      = tick_c && (tidx == SAMP_IDX);

  // Tick divider held in reload while idle so the phase follows the start edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tidx <= '0;
    end else if (state == IDLE) begin
      cnt  <= reload_idle_c;
      tidx <= '0;
    end else begin
      cnt  <= (cnt == '0) ? reload_run_c : cnt - CNT_W'(1);
      // Index wraps naturally, keeping every later sample at the middle of its bit
      if (tick_c) tidx <= tidx + IDX_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s6, s7;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s6 <= 1'b1;
      s7 <= 1'b1;
    end else begin
      if (tick_c && tidx == IDX_W'(6)) s6 <= rx_s;
      if (tick_c && tidx == IDX_W'(7)) s7 <= rx_s;
    end
  end
  assign bit_val_c = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
`else
  assign bit_val_c = rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d      = state;
    load_cfg_c   = 1'b0;
    shift_c      = 1'b0;
    par_sample_c = 1'b0;
    finish_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          load_cfg_c = 1'b1;
        end
      end
      START: begin
        if (decide_c) state_d = bit_val_c ? IDLE : DATA;
      end
      DATA: begin
        if (decide_c) begin
          shift_c = 1'b1;
          if (bit_cnt == (cfg_len ? 3'd7 : 3'd6)) state_d = cfg_par ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide_c) begin
          par_sample_c = 1'b1;
          state_d      = STOP;
        end
      end
      STOP: begin
        if (decide_c) begin
          finish_c = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame assembly and registered host outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_baud              <= 1'b0;
      cfg_par               <= 1'b0;
      cfg_len               <= 1'b0;
      bit_cnt               <= '0;
      shreg                 <= '0;
      par_acc               <= 1'b0;
      par_mis               <= 1'b0;
      rx_bus.data_out       <= '0;
      rx_bus.data_valid     <= 1'b0;
      rx_bus.parity_err     <= 1'b0;
      rx_bus.frame_err      <= 1'b0;
      rx_bus.busy           <= 1'b0;
    end else begin
      rx_bus.data_valid <= finish_c;
      rx_bus.busy       <= (state_d != IDLE);
      if (load_cfg_c) begin
        cfg_baud <= baud_rate;
        cfg_par  <= parity_switch;
        cfg_len  <= data_length;
        bit_cnt  <= '0;
        shreg    <= '0;
        par_acc  <= 1'b0;
        par_mis  <= 1'b0;
      end
      if (shift_c) begin
        shreg   <= {bit_val_c, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        par_acc <= par_acc ^ bit_val_c;
      end
      if (par_sample_c) par_mis <= par_acc ^ bit_val_c;
      if (finish_c) begin
        rx_bus.data_out   <= cfg_len ? shreg : {1'b0, shreg[7:1]};
        rx_bus.parity_err <= cfg_par & par_mis;
        rx_bus.frame_err  <= ~bit_val_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expectations, a monitor checks each strobe.
module tb_uart_rx;
  localparam int unsigned DIV_L = 64;
  localparam int unsigned DIV_H = 27;
  localparam int BIT_L = DIV_L * 16;
  localparam int BIT_H = DIV_H * 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  logic baud_rate, parity_switch, data_length;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   last_valid_cyc = 0;
  int   exp_lat;
  logic pulse_end = 1'b0;
  exp_t q[$];

  uart_rx_if u_if ();

  uart_rx #(.DIV_LOW(DIV_L), .DIV_HIGH(DIV_H)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .baud_rate     (baud_rate),
    .parity_switch (parity_switch),
    .data_length   (data_length),
    .rx_bus        (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation and last exactly one cycle
  always @(negedge clk) begin
    exp_t e;
    if (pulse_end) begin
      chk("valid_width", 32'(u_if.data_valid), 32'd0);
      pulse_end = 1'b0;
    end
    if (u_if.data_valid === 1'b1) begin
      last_valid_cyc = cyc;
      pulse_end = 1'b1;
      if (q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("data_out", 32'(u_if.data_out), 32'(e.data));
        chk("parity_err", 32'(u_if.parity_err), 32'(e.perr));
        chk("frame_err", 32'(u_if.frame_err), 32'(e.ferr));
      end
    end
  end

  // Caller is aligned to a falling clock edge
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic sbit, input int blen);
    rx_in = 1'b0;
    t_start = cyc;
    repeat (blen) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_in = d[i];
      repeat (blen) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (blen) @(negedge clk);
    end
    rx_in = sbit;
    repeat (blen) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data_out"}, 32'(u_if.data_out), 32'd0);
    chk({tag, "_data_valid"}, 32'(u_if.data_valid), 32'd0);
    chk({tag, "_parity_err"}, 32'(u_if.parity_err), 32'd0);
    chk({tag, "_frame_err"}, 32'(u_if.frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(u_if.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] partial;
    rst = 1'b0;
    rx_in = 1'b1;
    baud_rate = 1'b1;
    parity_switch = 1'b0;
    data_length = 1'b1;
    repeat (5) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 115200, 8N1, 0xA5 with latency check
    q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, BIT_H);
    exp_lat = 3 + (16 * 9 + 8) * int'(DIV_H);
`ifdef UART_RX_MAJORITY_EN
    exp_lat = exp_lat + int'(DIV_H);
`endif
    chk("latency_8n1", 32'(last_valid_cyc - t_start), 32'(exp_lat));
    chk("busy_after_a5", 32'(u_if.busy), 32'd0);
    repeat (20) @(negedge clk);

    // Low rate, 7 bits, even parity: good then bad parity bit
    baud_rate = 1'b0;
    parity_switch = 1'b1;
    data_length = 1'b0;
    repeat (5) @(negedge clk);
    q.push_back('{data: 8'h53, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h53, 7, 1'b1, 1'b0, 1'b1, BIT_L);
    repeat (20) @(negedge clk);
    q.push_back('{data: 8'h53, perr: 1'b1, ferr: 1'b0});
    send_frame(8'h53, 7, 1'b1, 1'b1, 1'b1, BIT_L);
    repeat (20) @(negedge clk);

    // 115200 8N, stop bit forced low
    baud_rate = 1'b1;
    parity_switch = 1'b0;
    data_length = 1'b1;
    repeat (5) @(negedge clk);
    q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, BIT_H);
    repeat (3 * BIT_H) @(negedge clk);
    chk("busy_after_ferr", 32'(u_if.busy), 32'd0);

    // Glitch shorter than half a bit: busy pulses, no strobe
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_during_glitch", 32'(u_if.busy), 32'd1);
    repeat (80) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * BIT_H) @(negedge clk);
    chk("busy_after_glitch", 32'(u_if.busy), 32'd0);

    // Reset during data bit 3 aborts the frame
    partial = 8'hC3;
    rx_in = 1'b0;
    repeat (BIT_H) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = partial[i];
      repeat (BIT_H) @(negedge clk);
    end
    rx_in = partial[3];
    repeat (BIT_H / 2) @(negedge clk);
    rx_in = 1'b1;
    rst = 1'b0;
    #1;
    chk_outputs_zero("midframe_reset");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, BIT_H);
    repeat (20) @(negedge clk);

    // Back-to-back 8E1 frames with no idle gap
    parity_switch = 1'b1;
    repeat (5) @(negedge clk);
    q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b0});
    q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1, BIT_H);
    send_frame(8'hFF, 8, 1'b1, 1'b0, 1'b1, BIT_H);
    repeat (2 * BIT_H) @(negedge clk);

    chk("pending_expectations", 32'(q.size()), 32'd0);
    chk("busy_final", 32'(u_if.busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
